// File: rtl/sel_4_1_scan_ctrl.sv
// Scan sequencer for a 4-1 selector: steps SEL over the enabled channels, dwells DWELL+1 cycles on each, samples SEL_IN.
// Optional continuous re-arm when SEL_SCAN_CONT_EN is defined (adds the CONT input).
module sel_4_1_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               STOP,
    input  logic [3:0]         MASK,
    input  logic [DWELL_W-1:0] DWELL,
    input  logic               SEL_IN,
`ifdef SEL_SCAN_CONT_EN
    input  logic               CONT,
`endif
    output logic [1:0]         SEL,
    output logic [3:0]         SAMPLE,
    output logic               VALID,
    output logic               BUSY
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         sel_reg, sel_next;
    logic [3:0]         sample_reg, sample_next;
    logic               valid_reg, valid_next;
    logic [DWELL_W-1:0] count_reg, count_next;
    logic [3:0]         acc_reg, acc_next;
    logic [3:0]         mask_reg, mask_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;

    logic [1:0]         first_idx;
    logic [1:0]         next_idx;
    logic               has_next;
    logic [3:0]         acc_cap;

    // Lowest channel of the live mask (used when arming) and next enabled channel above SEL in the shadow mask.
    always_comb begin
        first_idx = 2'd0;
        next_idx  = sel_reg;
        has_next  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (MASK[i]) first_idx = 2'(i);
            if (mask_reg[i] && (2'(i) > sel_reg)) begin
                next_idx = 2'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        acc_cap          = acc_reg;
        acc_cap[sel_reg] = SEL_IN;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg  <= IDLE;
            sel_reg    <= 2'd0;
            sample_reg <= 4'd0;
            valid_reg  <= 1'b0;
            count_reg  <= '0;
            acc_reg    <= 4'd0;
            mask_reg   <= 4'd0;
            dwell_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            sample_reg <= sample_next;
            valid_reg  <= valid_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            mask_reg   <= mask_next;
            dwell_reg  <= dwell_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        sample_next = sample_reg;
        valid_next  = 1'b0;
        count_next  = count_reg;
        acc_next    = acc_reg;
        mask_next   = mask_reg;
        dwell_next  = dwell_reg;
        case (state_reg)
            IDLE: begin
                if (START && !STOP && (MASK != 4'd0)) begin
                    mask_next  = MASK;
                    dwell_next = DWELL;
                    sel_next   = first_idx;
                    count_next = DWELL;
                    acc_next   = 4'd0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (STOP) begin
                    state_next = IDLE;
                end else if (count_reg != '0) begin
                    count_next = count_reg - {{(DWELL_W-1){1'b0}}, 1'b1};
                end else begin
                    acc_next = acc_cap;
                    if (has_next) begin
                        sel_next   = next_idx;
                        count_next = dwell_reg;
                    end else begin
                        sample_next = acc_cap;
                        valid_next  = 1'b1;
                        state_next  = IDLE;
`ifdef SEL_SCAN_CONT_EN
                        // Re-arm from the live inputs; an empty live mask lets the sweep end normally.
                        if (CONT && (MASK != 4'd0)) begin
                            mask_next  = MASK;
                            dwell_next = DWELL;
                            sel_next   = first_idx;
                            count_next = DWELL;
                            acc_next   = 4'd0;
                            state_next = SCAN;
                        end
`endif
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign SEL    = sel_reg;
    assign SAMPLE = sample_reg;
    assign VALID  = valid_reg;
    assign BUSY   = (state_reg == SCAN);

endmodule

// File: tb/tb_sel_4_1_scan_ctrl.sv
// Bench for sel_4_1_scan_ctrl: schedule-based sweep model checked every cycle, plus directed literal checks.
// Define SEL_SCAN_CONT_EN to also exercise the continuous-sweep option.
module tb_sel_4_1_scan_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N, START, STOP, SEL_IN;
    logic [3:0] MASK;
    logic [7:0] DWELL;
    logic [3:0] din;
    logic [1:0] SEL;
    logic [3:0] SAMPLE;
    logic       VALID, BUSY;
`ifdef SEL_SCAN_CONT_EN
    logic       CONT;
`endif

    always #5 CLK = ~CLK;

    sel_4_1_scan_ctrl #(.DWELL_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
        .MASK(MASK), .DWELL(DWELL), .SEL_IN(SEL_IN),
`ifdef SEL_SCAN_CONT_EN
        .CONT(CONT),
`endif
        .SEL(SEL), .SAMPLE(SAMPLE), .VALID(VALID), .BUSY(BUSY)
    );

    // The 4-1 selector itself: channel data din[i] appears on SEL_IN when SEL==i.
    assign SEL_IN = din[SEL];

    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a sweep is a list of enabled channels, each held for 'period' cycles; position follows from elapsed edges.
    logic [3:0] mm, macc, m_sample;
    logic [1:0] m_sel;
    logic       m_busy, m_valid;
    int         period, k, n;

    function automatic int nth_set(input logic [3:0] m, input int j);
        int cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (cnt == j) return i;
                cnt++;
            end
        end
        return 0;
    endfunction

    task automatic model_arm();
        mm     = MASK;
        period = int'(DWELL) + 1;
        n      = $countones(MASK);
        k      = 0;
        macc   = 4'd0;
        m_busy = 1'b1;
        m_sel  = 2'(nth_set(mm, 0));
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_busy = 1'b0; m_sel = 2'd0; m_sample = 4'd0; m_valid = 1'b0;
            mm = 4'd0; macc = 4'd0; k = 0; n = 0; period = 1;
        end else begin
            m_valid = 1'b0;
            if (m_busy) begin
                if (STOP) begin
                    m_busy = 1'b0;
                end else begin
                    k++;
                    if (k % period == 0) begin
                        int ch;
                        ch = nth_set(mm, (k - 1) / period);
                        macc[ch] = din[ch];
                    end
                    if (k == n * period) begin
                        m_sample = macc;
                        m_valid  = 1'b1;
                        m_busy   = 1'b0;
`ifdef SEL_SCAN_CONT_EN
                        if (CONT && MASK != 4'd0) model_arm();
`endif
                    end else begin
                        m_sel = 2'(nth_set(mm, k / period));
                    end
                end
            end else if (START && !STOP && MASK != 4'd0) begin
                model_arm();
            end
        end
    end

    always @(posedge CLK) begin
        #2;
        if (chk_en) begin
            check("sel", 32'(SEL), 32'(m_sel));
            check("sample", 32'(SAMPLE), 32'(m_sample));
            check("valid", 32'(VALID), 32'(m_valid));
            check("busy", 32'(BUSY), 32'(m_busy));
            if (VALID) valid_cnt++;
        end
    end

    task automatic run_sweep(input logic [3:0] m, input logic [7:0] d, input logic [3:0] m_after,
                             output int lat, output bit got);
        @(negedge CLK); MASK = m; DWELL = d; START = 1'b1;
        @(posedge CLK);
        @(negedge CLK); START = 1'b0; MASK = m_after;
        got = 1'b0; lat = 0;
        for (int i = 1; i < 3000 && !got; i++) begin
            @(posedge CLK); #2;
            if (VALID) begin got = 1'b1; lat = i; end
        end
        check("valid_seen", 32'(got), 32'd1);
        $display("sweep mask=%b dwell=%0d din=%b latency=%0d sample=%b", m, d, din, lat, SAMPLE);
    endtask

    initial begin
        int lat, vc;
        bit got;
        RST_N = 1'b0; START = 1'b0; STOP = 1'b0; MASK = 4'd0; DWELL = 8'd0; din = 4'd0;
`ifdef SEL_SCAN_CONT_EN
        CONT = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        check("rst_sel", 32'(SEL), 32'd0);
        check("rst_sample", 32'(SAMPLE), 32'd0);
        check("rst_valid", 32'(VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        RST_N = 1'b1; chk_en = 1'b1;

        din = 4'b1101;
        run_sweep(4'b1111, 8'd0, 4'b1111, lat, got);
        check("full_lat", 32'(lat), 32'd4);
        check("full_sample", 32'(SAMPLE), 32'b1101);

        din = 4'b1111;
        run_sweep(4'b1010, 8'd2, 4'b1010, lat, got);
        check("skip_lat", 32'(lat), 32'd6);
        check("skip_sample", 32'(SAMPLE), 32'b1010);

        // Abort on cycle 8 of a 24-cycle sweep.
        vc = valid_cnt;
        @(negedge CLK); MASK = 4'b1111; DWELL = 8'd5; START = 1'b1;
        @(posedge CLK);
        @(negedge CLK); START = 1'b0;
        repeat (7) @(negedge CLK);
        STOP = 1'b1;
        @(negedge CLK); STOP = 1'b0;
        check("abort_busy", 32'(BUSY), 32'd0);
        repeat (30) @(negedge CLK);
        check("abort_sample", 32'(SAMPLE), 32'b1010);
        check("abort_no_valid", 32'(valid_cnt), 32'(vc));
        $display("abort after 8 cycles busy=%b sample=%b", BUSY, SAMPLE);

        START = 1'b1; STOP = 1'b1;
        @(negedge CLK); START = 1'b0; STOP = 1'b0;
        check("start_stop_busy", 32'(BUSY), 32'd0);
        $display("start+stop in idle busy=%b", BUSY);

        MASK = 4'b0000; START = 1'b1;
        repeat (3) @(negedge CLK);
        START = 1'b0;
        check("mask0_busy", 32'(BUSY), 32'd0);
        check("mask0_no_valid", 32'(valid_cnt), 32'(vc));
        $display("start with mask=0000 busy=%b", BUSY);

        din = 4'b0110;
        run_sweep(4'b1111, 8'd1, 4'b0001, lat, got);
        check("shadow_lat", 32'(lat), 32'd8);
        check("shadow_sample", 32'(SAMPLE), 32'b0110);

        // Asynchronous reset while channel 2 is selected, mid-cycle.
        @(negedge CLK); MASK = 4'b1111; DWELL = 8'd3; START = 1'b1;
        @(posedge CLK);
        @(negedge CLK); START = 1'b0;
        repeat (9) @(posedge CLK);
        #3;
        check("pre_rst_sel", 32'(SEL), 32'd2);
        RST_N = 1'b0;
        #1;
        check("arst_sel", 32'(SEL), 32'd0);
        check("arst_sample", 32'(SAMPLE), 32'd0);
        check("arst_valid", 32'(VALID), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        $display("async reset mid-sweep sel=%b sample=%b busy=%b", SEL, SAMPLE, BUSY);
        @(negedge CLK); RST_N = 1'b1;

        din = 4'b0100;
        run_sweep(4'b0110, 8'd0, 4'b0110, lat, got);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_sample", 32'(SAMPLE), 32'b0100);

        din = 4'b1000;
        run_sweep(4'b1000, 8'hFF, 4'b1000, lat, got);
        check("max_dwell_lat", 32'(lat), 32'd256);
        check("max_dwell_sample", 32'(SAMPLE), 32'b1000);

`ifdef SEL_SCAN_CONT_EN
        begin
            int vt[$];
            din = 4'b0011; CONT = 1'b1;
            @(negedge CLK); MASK = 4'b0011; DWELL = 8'd1; START = 1'b1;
            @(posedge CLK);
            @(negedge CLK); START = 1'b0;
            for (int i = 1; i <= 30; i++) begin
                @(posedge CLK); #2;
                if (VALID) vt.push_back(i);
                if (i == 9) CONT = 1'b0;
            end
            check("cont_pulses", 32'(vt.size()), 32'd3);
            if (vt.size() == 3) begin
                check("cont_v0", 32'(vt[0]), 32'd4);
                check("cont_v1", 32'(vt[1]), 32'd8);
                check("cont_v2", 32'(vt[2]), 32'd12);
            end
            check("cont_end_busy", 32'(BUSY), 32'd0);
            check("cont_sample", 32'(SAMPLE), 32'b0011);
            $display("continuous sweep pulses=%0d busy=%b sample=%b", vt.size(), BUSY, SAMPLE);
        end
`endif

        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sel_4_1_scan_ctrl.md
Name: sel_4_1_scan_ctrl

Overview:
- Sequencer directly upstream of the 4-1 selector: drives its 2-bit SEL, steps through the four channels, and holds each channel for a programmable dwell time.
- Reads the selector's OUT back on SEL_IN and samples it at the end of each dwell.
- After a full sweep of enabled channels, presents a 4-bit snapshot with a one-cycle VALID pulse.
- Sits between a control/register block (START/STOP/MASK/DWELL) and the combinational selector.

Parameters:
- DWELL_W, 8, width of the dwell count; per-channel hold time is DWELL+1 cycles, range 1 to 2^DWELL_W.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  begin one sweep (level sampled each clock)
- STOP  in  1  abort current sweep
- MASK  in  4  channel enable, bit i = channel i (SEL value i)
- DWELL  in  DWELL_W  hold count per channel (cycles minus one)
- SEL_IN  in  1  selector OUT fed back
- SEL  out  2  channel select to the 4-1 selector
- SAMPLE  out  4  snapshot, bit i = SEL_IN sampled on channel i; 0 for masked channels
- VALID  out  1  one-cycle pulse, SAMPLE updated this cycle
- BUSY  out  1  sweep in progress

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE, SEL=2'b00, SAMPLE=4'b0000, VALID=0, BUSY=0, internal count, accumulator and shadow registers cleared.
- State IDLE:
  - BUSY=0; SEL and SAMPLE hold their last values.
  - START=1, STOP=0, MASK!=0 at a rising edge:
    - latch MASK and DWELL into shadow registers
    - SEL <= index of the lowest set MASK bit
    - count <= DWELL
    - accumulator <= 0
    - go to SCAN
  - START with MASK==0: ignored. No state change, no VALID.
  - START and STOP together: STOP wins; stay IDLE.
- State SCAN:
  - BUSY=1. SEL is constant for DWELL+1 cycles per channel.
  - Each edge with count!=0: count decrements.
  - Edge with count==0: accumulator[SEL] <= SEL_IN. Then:
    - If a higher-index shadow-MASK bit is set: SEL <= next higher set index, count <= shadow DWELL, stay in SCAN. Masked channels are skipped with zero cycles spent.
    - Else (last enabled channel): SAMPLE <= accumulator including this bit, VALID <= 1 for exactly one cycle, go to IDLE.
  - STOP=1 at any edge in SCAN: go to IDLE, no VALID, SAMPLE unchanged, SEL holds the current value. STOP outranks the final capture on the same edge.
  - START in SCAN: ignored.
  - MASK/DWELL changes in SCAN: no effect until the next START (shadow copies are used).
- Latency: with START sampled at edge t and N enabled channels, VALID is high in the cycle following edge t + N*(DWELL+1). BUSY is high from edge t to that same edge.
- Width: count is DWELL_W bits, unsigned. DWELL=all-ones gives 2^DWELL_W cycles per channel, with no wrap issues (reload happens only at zero).
- SEL_IN is assumed settled by the sample edge because SEL is registered. No synchroniser is included; SEL_IN must be in the CLK domain.

Optional Feature:
- Macro SEL_SCAN_CONT_EN.
- Defined:
  - Adds input port CONT (1 bit).
  - At the final-capture edge with CONT=1 and STOP=0: VALID pulses as normal, then shadow MASK/DWELL are re-latched from the live inputs and the sweep restarts.
  - SEL goes to the lowest enabled channel on that same edge; BUSY stays 1.
  - If the live MASK==0 at restart: go to IDLE instead.
- Not defined: no CONT port; every sweep ends in IDLE.

Test Plan:
- Reset mid-sweep: MASK=1111, DWELL=3, assert RST_N=0 during channel 2 -> SEL=00, SAMPLE=0000, VALID=0, BUSY=0 immediately, without waiting for a clock.
- Full sweep: MASK=1111, DWELL=0, selector inputs A..D=1,0,1,1, START one cycle -> SEL 00,01,10,11 on consecutive cycles; VALID once 4 cycles after START edge; SAMPLE=4'b1101.
- Masked skip: MASK=1010, DWELL=2, A..D=1,1,1,1 -> SEL visits only 01 then 11, 3 cycles each; VALID at 6 cycles; SAMPLE=4'b1010.
- Abort: MASK=1111, DWELL=5, STOP on cycle 8 -> IDLE next cycle, no VALID, SAMPLE keeps previous value. START+STOP together in IDLE -> BUSY stays 0.
- Ignored inputs: START with MASK=0000 -> no BUSY, no VALID. MASK changed 1111->0001 mid-sweep -> sweep completes all 4 channels.
- With SEL_SCAN_CONT_EN: CONT=1, MASK=0011, DWELL=1 -> VALID every 4 cycles, BUSY continuously 1. Drop CONT -> ends in IDLE after the current sweep.
